// File: rtl/vga_cap_pkg.sv
// Shared types and constants for the VGA frame capture block.
package vga_cap_pkg;

    typedef enum logic [1:0] {
        S_WAIT,
        S_FRAME,
        S_FRAME_END
    } state_e;

    // Default timing: 256x240 visible area, two clocks per pixel.
    localparam int unsigned DefHActive = 256;
    localparam int unsigned DefVActive = 240;
    localparam int unsigned DefPixDiv  = 2;

    // 3-bit colour codes as driven on rgb.
    localparam logic [2:0] ColBlack   = 3'd0;
    localparam logic [2:0] ColBlue    = 3'd1;
    localparam logic [2:0] ColGreen   = 3'd2;
    localparam logic [2:0] ColCyan    = 3'd3;
    localparam logic [2:0] ColRed     = 3'd4;
    localparam logic [2:0] ColMagenta = 3'd5;
    localparam logic [2:0] ColYellow  = 3'd6;
    localparam logic [2:0] ColWhite   = 3'd7;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/vga_frame_capture_if.sv
// Video input and frame-buffer write bundle. master = video source / sink
// consumer side, slave = the capture block.
interface vga_frame_capture_if #(
    parameter int unsigned AW = 16
);
    logic          hsync;
    logic          vsync;
    logic [2:0]    rgb;
    logic          capture_en;
    logic          err_clr;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [2:0]    wr_data;
    logic          frame_done;
    logic [15:0]   frame_cnt;
    logic [15:0]   line_len;
    logic          sync_err;

    modport master (
        output hsync, vsync, rgb, capture_en, err_clr,
        input  wr_en, wr_addr, wr_data, frame_done, frame_cnt, line_len, sync_err
    );

    modport slave (
        input  hsync, vsync, rgb, capture_en, err_clr,
        output wr_en, wr_addr, wr_data, frame_done, frame_cnt, line_len, sync_err
    );
endinterface

// File: rtl/sync_edge_det.sv
// Registers a sync input and derives one-cycle rise/fall pulses from it.
module sync_edge_det #(
    parameter logic IdleVal = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic sig_i,
    output logic sig_q_o,
    output logic rise_o,
    output logic fall_o
);
    logic sig_q;
    logic sig_qq;

    // Two-stage register; resetting to the idle level avoids a false edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            sig_q  <= IdleVal;
            sig_qq <= IdleVal;
        end else begin
            sig_q  <= sig_i;
            sig_qq <= sig_q;
        end
    end

    assign sig_q_o = sig_q;
    assign rise_o  = sig_q & ~sig_qq;
    assign fall_o  = ~sig_q & sig_qq;

endmodule

// File: rtl/vga_frame_capture.sv
// Rebuilds pixel coordinates from an hsync/vsync/rgb stream and writes the
// visible window into an external frame buffer.
module vga_frame_capture
    import vga_cap_pkg::*;
#(
    parameter int unsigned PIX_DIV  = DefPixDiv,
    parameter int unsigned H_SKIP   = 0,
    parameter int unsigned V_SKIP   = 0,
    parameter int unsigned H_ACTIVE = DefHActive,
    parameter int unsigned V_ACTIVE = DefVActive,
    parameter int unsigned AW       = $clog2(H_ACTIVE * V_ACTIVE)
) (
    input  logic               clk,
    input  logic               reset,
    vga_frame_capture_if.slave bus
);

    logic hs_q, hs_rise, hs_fall;
    logic vs_q, vs_rise, vs_fall;
    logic [2:0] rgb_q;

    state_e state_q, state_d;

    logic [15:0] lc_q, lc_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] ph_q, ph_d;
    logic [15:0] len_cnt_q, len_cnt_d;
    logic [15:0] line_len_q, line_len_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic        started_q, started_d;
    logic        sync_err_q, sync_err_d;
    logic        frame_done_q, frame_done_d;
    logic        wr_en_q, wr_en_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [2:0]  wr_data_q, wr_data_d;

    logic        tick, in_x, in_y;
    logic        len_mismatch, short_line, short_frame;
    logic [16:0] x_diff, y_diff;

    sync_edge_det #(.IdleVal(1'b1)) u_hs_edge (
        .clk    (clk),
        .reset  (reset),
        .sig_i  (bus.hsync),
        .sig_q_o(hs_q),
        .rise_o (hs_rise),
        .fall_o (hs_fall)
    );

    sync_edge_det #(.IdleVal(1'b1)) u_vs_edge (
        .clk    (clk),
        .reset  (reset),
        .sig_i  (bus.vsync),
        .sig_q_o(vs_q),
        .rise_o (vs_rise),
        .fall_o (vs_fall)
    );

    // Colour input register, aligned with hs_q/vs_q.
    always_ff @(posedge clk) begin
        if (reset) begin
            rgb_q <= 3'd0;
        end else begin
            rgb_q <= bus.rgb;
        end
    end

    assign tick = (ph_q == 16'(PIX_DIV - 1));

    // A 17-bit difference wraps negative offsets to large values, so a
    // single compare covers both window edges.
    assign x_diff = {1'b0, pc_q} - 17'(H_SKIP);
    assign y_diff = {1'b0, lc_q} - 17'(V_SKIP);
    assign in_x   = (x_diff < 17'(H_ACTIVE));
    assign in_y   = (y_diff < 17'(V_ACTIVE));

    assign short_line  = hs_fall && in_y && (pc_q < 16'(H_SKIP + H_ACTIVE));
    assign short_frame = vs_fall && (lc_q < 16'(V_SKIP + V_ACTIVE));

    // Frame FSM: arm on vsync end, close the frame on the next vsync start.
    always_comb begin
        state_d      = state_q;
        frame_done_d = 1'b0;
        frame_cnt_d  = frame_cnt_q;
        unique case (state_q)
            S_WAIT: begin
                if (vs_rise && bus.capture_en) state_d = S_FRAME;
            end
            S_FRAME: begin
                if (vs_fall) begin
                    state_d      = S_FRAME_END;
                    frame_done_d = 1'b1;
                    frame_cnt_d  = frame_cnt_q + 16'd1;
                end
            end
            S_FRAME_END: begin
                if (vs_rise) state_d = bus.capture_en ? S_FRAME : S_WAIT;
            end
            default: state_d = S_WAIT;
        endcase
    end

    // Position counters, line-length measurement, error flag and write port.
    always_comb begin
        lc_d         = lc_q;
        pc_d         = pc_q;
        ph_d         = ph_q;
        len_cnt_d    = sat_inc16(len_cnt_q);
        line_len_d   = line_len_q;
        started_d    = started_q;
        len_mismatch = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;

        if (vs_rise) begin
            lc_d = 16'd0;
        end else if (hs_rise) begin
            lc_d = sat_inc16(lc_q);
        end

        if (hs_rise) begin
            ph_d = 16'd0;
            pc_d = 16'd0;
        end else begin
            ph_d = tick ? 16'd0 : ph_q + 16'd1;
            if (tick) pc_d = sat_inc16(pc_q);
        end

        // The first hs_rise after reset only starts the clock count.
        if (hs_rise) begin
            len_cnt_d = 16'd1;
            started_d = 1'b1;
            if (started_q) begin
                line_len_d   = len_cnt_q;
                len_mismatch = (line_len_q != 16'd0) && (len_cnt_q != line_len_q);
            end
        end

        if (len_mismatch || short_line || short_frame) begin
            sync_err_d = 1'b1;
        end else if (bus.err_clr) begin
            sync_err_d = 1'b0;
        end else begin
            sync_err_d = sync_err_q;
        end

        // pc/lc still hold the previous line on the hs_rise cycle, so skip it.
        wr_en_d = tick && !hs_rise && (state_q == S_FRAME) && in_x && in_y && hs_q && vs_q;
        if (wr_en_d) begin
            wr_addr_d = AW'(32'(y_diff[15:0]) * H_ACTIVE + 32'(x_diff[15:0]));
            wr_data_d = rgb_q;
        end
    end

    // State and output registers. lc/pc start saturated so no window or
    // short-line check fires before the first real sync edges are seen.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_WAIT;
            lc_q         <= 16'hFFFF;
            pc_q         <= 16'hFFFF;
            ph_q         <= 16'd0;
            len_cnt_q    <= 16'd0;
            line_len_q   <= 16'd0;
            frame_cnt_q  <= 16'd0;
            started_q    <= 1'b0;
            sync_err_q   <= 1'b0;
            frame_done_q <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= 3'd0;
        end else begin
            state_q      <= state_d;
            lc_q         <= lc_d;
            pc_q         <= pc_d;
            ph_q         <= ph_d;
            len_cnt_q    <= len_cnt_d;
            line_len_q   <= line_len_d;
            frame_cnt_q  <= frame_cnt_d;
            started_q    <= started_d;
            sync_err_q   <= sync_err_d;
            frame_done_q <= frame_done_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
        end
    end

    assign bus.wr_en      = wr_en_q;
    assign bus.wr_addr    = wr_addr_q;
    assign bus.wr_data    = wr_data_q;
    assign bus.frame_done = frame_done_q;
    assign bus.frame_cnt  = frame_cnt_q;
    assign bus.line_len   = line_len_q;
    assign bus.sync_err   = sync_err_q;

endmodule

// File: tb/tb_vga_frame_capture.sv
// Directed bench for vga_frame_capture on a 4x3 window, two clocks per pixel.
module tb_vga_frame_capture;

    localparam int HA  = 4;
    localparam int VA  = 3;
    localparam int AWB = 4;
    localparam int HS  = 4;   // hsync pulse width in clocks
    localparam int LP  = 20;  // nominal line period in clocks

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    vga_frame_capture_if #(.AW(AWB)) bus ();

    vga_frame_capture #(
        .PIX_DIV (2),
        .H_SKIP  (0),
        .V_SKIP  (0),
        .H_ACTIVE(HA),
        .V_ACTIVE(VA),
        .AW      (AWB)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_bad    = 0;
    int cyc_no   = 0;
    int fd_cycles = 0;
    int vs_rise_cyc = 0;
    int wr_mark = 0;
    int base;
    int unsigned wa_log[$];
    int unsigned wd_log[$];
    int          wc_log[$];

    always @(posedge clk) cyc_no <= cyc_no + 1;

    // Record every write and frame_done cycle, sampled mid-period.
    always @(negedge clk) begin
        if (bus.wr_en === 1'b1) begin
            wa_log.push_back(32'(bus.wr_addr));
            wd_log.push_back(32'(bus.wr_data));
            wc_log.push_back(cyc_no);
        end
        if (bus.frame_done === 1'b1) fd_cycles = fd_cycles + 1;
    end

    task automatic check_val(input string tag, input int unsigned got, input int unsigned exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check_val({tag, "_wr_en"}, 32'(bus.wr_en), 0);
        check_val({tag, "_wr_addr"}, 32'(bus.wr_addr), 0);
        check_val({tag, "_wr_data"}, 32'(bus.wr_data), 0);
        check_val({tag, "_frame_done"}, 32'(bus.frame_done), 0);
        check_val({tag, "_frame_cnt"}, 32'(bus.frame_cnt), 0);
        check_val({tag, "_line_len"}, 32'(bus.line_len), 0);
        check_val({tag, "_sync_err"}, 32'(bus.sync_err), 0);
    endtask

    // One line: HS clocks of hsync low (vsync low too if vs_pulse), then
    // hsync high with one pad clock and npix pixels of two clocks, rgb=x+row.
    task automatic drive_line(input bit vs_pulse, input int row, input int npix,
                              input int period, input bit clr, input int rst_at);
        int k;
        for (int i = 0; i < period; i++) begin
            bus.err_clr = (clr && i == 0) ? 1'b1 : 1'b0;
            if (i < HS) begin
                bus.hsync = 1'b0;
                bus.vsync = vs_pulse ? 1'b0 : 1'b1;
                bus.rgb   = 3'd0;
            end else begin
                bus.hsync = 1'b1;
                bus.vsync = 1'b1;
                k = i - HS;
                if (k == 0 && vs_pulse) vs_rise_cyc = cyc_no;
                if (k >= 1 && k < 1 + 2 * npix) bus.rgb = 3'((k - 1) / 2 + row);
                else bus.rgb = 3'd0;
            end
            if (i == rst_at) reset = 1'b1;
            cyc();
            if (i == rst_at) begin
                reset = 1'b0;
                check_zero("midrst");
                wr_mark = wa_log.size();
            end
        end
        bus.err_clr = 1'b0;
    endtask

    task automatic drive_frame(input int rows, input int wide_row, input int drop_row,
                               input int rst_row, input bit blank);
        for (int r = 0; r < rows; r++) begin
            if (r == drop_row) bus.capture_en = 1'b0;
            drive_line(r == 0, r, (r == wide_row) ? 6 : 4, LP, 1'b0, (r == rst_row) ? 10 : -1);
        end
        if (blank) drive_line(1'b0, 0, 0, LP, 1'b0, -1);
    endtask

    task automatic check_frame(input int b, input int rows);
        int n;
        n = wa_log.size() - b;
        check_val("wr_count", n, rows * HA);
        for (int i = 0; i < rows * HA && i < n; i++) begin
            check_val("wr_addr", wa_log[b+i], i);
            check_val("wr_data", wd_log[b+i], (i % HA) + (i / HA));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        bus.hsync = 1'b1;
        bus.vsync = 1'b1;
        bus.rgb = 3'd0;
        bus.capture_en = 1'b0;
        bus.err_clr = 1'b0;
        repeat (3) cyc();
        check_zero("reset");
        reset = 1'b0;

        // Line-length measurement and error flag
        drive_line(1'b0, 0, 0, LP, 1'b0, -1);
        check_val("len_first", 32'(bus.line_len), 0);
        drive_line(1'b0, 0, 0, LP, 1'b0, -1);
        drive_line(1'b0, 0, 0, LP, 1'b0, -1);
        check_val("len_20", 32'(bus.line_len), 20);
        check_val("err_steady", 32'(bus.sync_err), 0);
        drive_line(1'b0, 0, 0, 22, 1'b0, -1);
        drive_line(1'b0, 0, 0, LP, 1'b0, -1);
        check_val("len_22", 32'(bus.line_len), 22);
        check_val("err_len", 32'(bus.sync_err), 1);
        drive_line(1'b0, 0, 0, LP, 1'b0, -1);
        drive_line(1'b0, 0, 0, LP, 1'b1, -1);
        check_val("err_clr", 32'(bus.sync_err), 0);
        check_val("len_back", 32'(bus.line_len), 20);

        // Frame 1: full capture
        bus.capture_en = 1'b1;
        base = wa_log.size();
        drive_frame(3, -1, -1, -1, 1'b1);
        check_frame(base, 3);
        if (wd_log.size() > base + 5) check_val("data_addr5", wd_log[base+5], 2);
        else check_val("data_addr5_missing", 0, 1);
        if (wc_log.size() > base) check_val("latency", wc_log[base] - vs_rise_cyc, 4);
        check_val("fd_f1", fd_cycles, 0);

        // Frame 2: capture_en dropped mid-frame, still completes
        base = wa_log.size();
        drive_frame(3, -1, 1, -1, 1'b1);
        check_frame(base, 3);
        check_val("cnt_f2", 32'(bus.frame_cnt), 1);
        check_val("fd_f2", fd_cycles, 1);

        // Frame 3: not armed
        base = wa_log.size();
        drive_frame(3, -1, -1, -1, 1'b1);
        check_val("wr_count_f3", wa_log.size() - base, 0);
        check_val("cnt_f3", 32'(bus.frame_cnt), 2);
        check_val("fd_f3", fd_cycles, 2);

        // Frame 4: vsync after only two lines
        bus.capture_en = 1'b1;
        base = wa_log.size();
        drive_frame(2, -1, -1, -1, 1'b0);
        check_frame(base, 2);
        check_val("err_pre_short", 32'(bus.sync_err), 0);

        // Frame 5: row 1 carries six pixels
        base = wa_log.size();
        drive_frame(3, 1, -1, -1, 1'b1);
        check_frame(base, 3);
        check_val("err_short", 32'(bus.sync_err), 1);
        check_val("cnt_f5", 32'(bus.frame_cnt), 3);
        check_val("fd_f5", fd_cycles, 3);

        // Frame 6: reset in line 1, nothing more written this frame
        drive_frame(3, -1, -1, 1, 1'b1);
        check_val("wr_after_rst", wa_log.size() - wr_mark, 0);

        // Frame 7: fresh vsync restarts capture
        base = wa_log.size();
        drive_frame(3, -1, -1, -1, 1'b1);
        check_frame(base, 3);
        drive_line(1'b1, 0, 0, LP, 1'b0, -1);
        check_val("cnt_f7", 32'(bus.frame_cnt), 1);
        check_val("fd_f7", fd_cycles, 5);
        check_val("err_f7", 32'(bus.sync_err), 0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule

// File: doc/vga_frame_capture.md
Name: vga_frame_capture

Overview:
- Synthesizable sink for the video side of the game wrappers: takes the hsync/vsync/rgb stream that a game drives and rebuilds pixel coordinates from it.
- Writes each visible pixel into an external frame buffer through a simple write port.
- Reports frame completion, a frame count, the measured line length and a sticky sync-error flag.
- Sits beside any wrapper_* game block, in FPGA loopback or in simulation. It is the hardware counterpart of the ASCII frame logger.

Parameters:
- PIX_DIV, 2, clocks per pixel (at least 1).
- H_SKIP, 0, pixel ticks after the end of hsync before column 0.
- V_SKIP, 0, lines after the end of vsync before row 0.
- H_ACTIVE, 256, columns captured per line.
- V_ACTIVE, 240, rows captured per frame.
- AW, $clog2(H_ACTIVE*V_ACTIVE), frame buffer address width.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous active-high reset.
- hsync  in  1  horizontal sync; active-low pulse, idle high.
- vsync  in  1  vertical sync; active-low pulse, idle high.
- rgb  in  3  pixel colour.
- capture_en  in  1  arm capture; sampled only at frame start.
- err_clr  in  1  clears sync_err.
- wr_en  out  1  frame buffer write strobe.
- wr_addr  out  AW  write address, y*H_ACTIVE+x.
- wr_data  out  3  pixel colour to write.
- frame_done  out  1  one-cycle pulse at the end of a captured frame.
- frame_cnt  out  16  number of captured frames; wraps from 0xFFFF to 0.
- line_len  out  16  clocks between the last two hsync rising edges.
- sync_err  out  1  sticky timing error flag.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on reset.
- Input stage: hsync, vsync and rgb are registered once (hs_q, vs_q, rgb_q). A second register on hs_q/vs_q gives the edges:
  - hs_rise: end of hsync pulse. hs_fall: start of hsync pulse.
  - vs_rise: end of vsync pulse. vs_fall: start of vsync pulse.
- Reset: every output is 0 and the FSM is in S_WAIT.
- FSM states:
  - S_WAIT: idle, no writes. Moves to S_FRAME on vs_rise when capture_en=1.
  - S_FRAME: capturing. On vs_fall, pulse frame_done and increment frame_cnt. Then go to S_FRAME_END.
  - S_FRAME_END: waits for vs_rise. If capture_en=1 go to S_FRAME, otherwise go to S_WAIT. Deasserting capture_en mid-frame never cuts a frame short.
- Line counter lc:
  - Cleared to 0 on vs_rise.
  - Increments on each hs_rise; saturates at 0xFFFF.
  - On a cycle with both hs_rise and vs_rise, vs_rise wins and lc=0.
- Pixel divider ph:
  - Cleared to 0 on hs_rise.
  - Otherwise counts modulo PIX_DIV.
  - tick = (ph == PIX_DIV-1).
- Column counter pc: cleared on hs_rise; increments on tick; saturates.
- Coordinates: x = pc - H_SKIP and y = lc - V_SKIP, where H_SKIP ≤ pc < H_SKIP+H_ACTIVE and V_SKIP ≤ lc < V_SKIP+V_ACTIVE.
- Write rule:
  - wr_en=1 for one clock on a tick, in S_FRAME, with both coordinates in the window and hs_q=1 and vs_q=1.
  - wr_data = rgb_q and wr_addr = y*H_ACTIVE+x, both registered.
  - Latency: wr_en/wr_addr/wr_data appear 2 clocks after the rgb value is on the pins.
- Pixels outside the window are discarded silently. No address wraps, and nothing outside the window is ever written.
- line_len:
  - A 16-bit clock counter runs from one hs_rise to the next and is loaded into line_len on each hs_rise.
  - Saturates at 0xFFFF.
  - The first hs_rise after reset only starts the count; line_len stays 0 until the second.
- sync_err is set on any of:
  - a new line_len that differs from the previous nonzero line_len;
  - hs_fall while pc < H_SKIP+H_ACTIVE on a line inside the row window (short line);
  - vs_fall while lc < V_SKIP+V_ACTIVE (short frame).
- sync_err is cleared only by reset or err_clr; set has priority when both happen on the same clock.
- Reset in mid-frame: everything returns to S_WAIT at once, and wr_en is 0 from the next clock.

Decomposition:
- Package vga_cap_pkg holds:
  - the state enum (S_WAIT, S_FRAME, S_FRAME_END);
  - default timing constants (256x240, PIX_DIV=2);
  - the colour code constants 0..7.
- One sub-module, sync_edge_det: register plus rise/fall pulses, instantiated once each for hsync and vsync.

Test Plan (bench with H_ACTIVE=4, V_ACTIVE=3, PIX_DIV=2, H_SKIP=V_SKIP=0):
- Stimulus: reset, capture_en=1, one frame of 3 lines, each line 4 pixels of 2 clocks with rgb=x+y, hsync pulses between lines. Response: 12 writes, addresses 0..11, wr_data(addr 5)=2, then one frame_done pulse and frame_cnt=1.
- Stimulus: line period 20 clocks for several lines. Response: line_len=20 after the second hs_rise, sync_err=0. Then one 22-clock line: sync_err=1 and line_len=22. Then err_clr: sync_err=0.
- Stimulus: capture_en deasserted in the middle of frame 2. Response: frame 2 completes (12 writes, frame_cnt=2), and frame 3 produces no writes.
- Stimulus: vsync pulse after only 2 lines. Response: sync_err=1, frame_done still pulses, and no writes with address ≥ 8.
- Stimulus: a line with 6 pixels. Response: only 4 writes on that line, pixels 4 and 5 dropped, and the next address follows the row pattern.
- Stimulus: reset asserted during line 1. Response: wr_en=0 on the next clock, all outputs 0, and capture restarts only after a fresh vs_rise.
